alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `ALU32Bit` instance among `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the shared ALU's `ALUControl`/`A`/`B` from registers. After a programmable settle time it captures `ALUResult`/`Zero` and returns them, tagged with the requester index, over a valid/ready response channel. It sits between the ALU and any blocks (sequencers, test drivers) that need ALU time.

---
 rtl/alu_share_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational ALU32Bit among NUM_REQ requesters. One operation
// is accepted at a time over a valid/ready handshake, chosen round-robin.
// The chosen operation is held in registers that drive the shared ALU. After
// SETTLE cycles the ALU result and Zero flag are captured and returned with
// the requester index over a valid/ready response channel.
//
// Parameters:
//   NUM_REQ  number of requesters (2..16)
//   ID_W     requester index width
//   SETTLE   cycles the ALU inputs are held before capture (1..15)
//
// Ports:
//   sys_clk      clock, rising edge
//   sys_rst      synchronous active-high reset
//   req_valid    per-requester request valid
//   req_ready    per-requester accept, at most one bit set
//   req_op       ALUControl per requester, slice i = [4i+3:4i]
//   req_a/req_b  operands per requester, slice i = [32i+31:32i]
//   alu_control  to ALU ALUControl
//   alu_a/alu_b  to ALU A/B
//   alu_result   from ALU ALUResult
//   alu_zero     from ALU Zero
//   rsp_valid    response valid
//   rsp_ready    response accept
//   rsp_id       index of the requester served
//   rsp_result   captured ALU result
//   rsp_zero     captured ALU Zero flag
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int SETTLE  = 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [3:0]              alu_control,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    input  logic [31:0]             alu_result,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    rsp_zero
);

    localparam int IDX_W = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [3:0]        settle_cnt;
    logic [ID_W-1:0]   grant;
    logic              any_valid;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        sel_op;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;

    // Round-robin search: walk the offsets from the highest down to zero so
    // that the last hit written is the valid requester closest to rr_ptr.
    // The index is formed one bit wider than ID_W so rr_ptr+offset can be
    // wrapped back into range without overflowing.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            idx = {1'b0, rr_ptr} + IDX_W'(j);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (req_valid[idx[ID_W-1:0]]) begin
                grant     = idx[ID_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    // Select the granted requester's payload with constant slices, one
    // comparison per requester, so no variable part-select is needed.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_op = req_op[4*i +: 4];
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
            end
        end
    end

    // Next-state and request accept. Ready is offered only in IDLE and is
    // gated by reset, so nothing is accepted on a reset edge. The granted
    // bit is valid by construction, so accept is simply "someone is valid".
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid && !sys_rst) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_next       = EXEC;
                end
            end
            EXEC: begin
                if (settle_cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. The ALU input registers load only on a
    // request handshake and otherwise keep their last values. The response
    // fields load once when the settle count expires and stay stable for as
    // long as the response is back-pressured. The round-robin pointer moves
    // past the served requester only when its response is taken, so a reset
    // mid-operation restarts the search from requester 0.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            settle_cnt  <= '0;
            alu_control <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_control <= sel_op;
                        alu_a       <= sel_a;
                        alu_b       <= sel_b;
                        cur_id      <= grant;
                        settle_cnt  <= 4'(SETTLE - 1);
                    end
                end
                EXEC: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_id     <= cur_id;
                        rsp_valid  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Bench for alu_share_arbiter. Two instances run side by side: dut0 with
// SETTLE=1 and dut1 with SETTLE=3, each with its own behavioural ALU on the
// alu_* ports. Directed sequences cover the single request, continuous
// round-robin, response back-pressure, the longer settle time, reset during
// execution and the zero flag; a random phase follows. A negedge monitor
// keeps a round-robin model and a queue of expected responses per instance.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        longint      hs_edge;
    } exp_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [N-1:0]      req_valid   [2];
    logic [N-1:0]      req_ready   [2];
    logic [4*N-1:0]    req_op      [2];
    logic [32*N-1:0]   req_a       [2];
    logic [32*N-1:0]   req_b       [2];
    logic [3:0]        alu_control [2];
    logic [31:0]       alu_a       [2];
    logic [31:0]       alu_b       [2];
    logic [31:0]       alu_result  [2];
    logic              alu_zero    [2];
    logic              rsp_valid   [2];
    logic              rsp_ready   [2];
    logic [IW-1:0]     rsp_id      [2];
    logic [31:0]       rsp_result  [2];
    logic              rsp_zero    [2];

    int      errors = 0;
    int      checks = 0;
    longint  cyc = 0;
    bit      rst_prev = 1'b0;
    bit      started = 1'b0;
    bit      timeout_hit = 1'b0;
    bit      end_check = 1'b0;
    bit      end_done = 1'b0;

    exp_t          sb       [2][$];
    exp_t          cur_exp  [2];
    bit            busy     [2];
    bit            holding  [2];
    int            ptr      [2];
    logic [67:0]   last_pay [2];

    // Behavioural ALU32Bit: MIPS-style codes plus a few extras; unused codes
    // return zero.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd3:    r = a ^ b;
            4'd4:    r = a << b[4:0];
            4'd5:    r = a >> b[4:0];
            4'd6:    r = a - b;
            4'd7:    r = {31'd0, $signed(a) < $signed(b)};
            4'd8:    r = {31'd0, a < b};
            4'd9:    r = 32'($signed(a) >>> b[4:0]);
            4'd10:   r = a * b;
            4'd12:   r = ~(a | b);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // First valid requester at or after p, wrapping; -1 when none is valid.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int j = 0; j < N; j++) begin
            if (v[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        alu_share_arbiter #(
            .NUM_REQ (N),
            .SETTLE  (k == 0 ? 1 : 3)
        ) u_dut (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .req_valid   (req_valid[k]),
            .req_ready   (req_ready[k]),
            .req_op      (req_op[k]),
            .req_a       (req_a[k]),
            .req_b       (req_b[k]),
            .alu_control (alu_control[k]),
            .alu_a       (alu_a[k]),
            .alu_b       (alu_b[k]),
            .alu_result  (alu_result[k]),
            .alu_zero    (alu_zero[k]),
            .rsp_valid   (rsp_valid[k]),
            .rsp_ready   (rsp_ready[k]),
            .rsp_id      (rsp_id[k]),
            .rsp_result  (rsp_result[k]),
            .rsp_zero    (rsp_zero[k])
        );
        assign alu_result[k] = alu_fn(alu_control[k], alu_a[k], alu_b[k]);
        assign alu_zero[k]   = (alu_result[k] == 32'd0);
    end

    task automatic checkOutput(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: actual=%0h expected=%0h", name, k, act, exp);
        end
    endtask

    // Monitor and scoreboard. Each falling edge it checks what the DUT shows
    // now against the model, then advances the model for the coming edge.
    always @(negedge sys_clk) begin
        int           s;
        int           g;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        if (rst_prev) started = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? 1 : 3;
            if (started) begin
                if (rst_prev) begin
                    checkOutput("reset_outputs", k,
                        {alu_control[k], alu_a[k], alu_b[k], rsp_valid[k], rsp_id[k], rsp_result[k], rsp_zero[k]}, '0);
                end
                if (rsp_valid[k]) begin
                    if (!holding[k]) begin
                        if (sb[k].size() == 0) begin
                            checkOutput("spurious_rsp", k, rsp_valid[k], 1'b0);
                        end else begin
                            cur_exp[k] = sb[k].pop_front();
                            holding[k] = 1'b1;
                            checkOutput("latency", k, cyc - cur_exp[k].hs_edge, s);
                        end
                    end
                    if (holding[k]) begin
                        checkOutput("rsp_id", k, rsp_id[k], cur_exp[k].id);
                        checkOutput("rsp_result", k, rsp_result[k], cur_exp[k].res);
                        checkOutput("rsp_zero", k, rsp_zero[k], cur_exp[k].zero);
                    end
                end else begin
                    if (holding[k]) begin
                        checkOutput("rsp_valid_held", k, rsp_valid[k], 1'b1);
                        holding[k] = 1'b0;
                        busy[k]    = 1'b0;
                    end
                    if (sb[k].size() > 0 && cyc - sb[k][0].hs_edge >= s) begin
                        checkOutput("rsp_missing", k, rsp_valid[k], 1'b1);
                        e = sb[k].pop_front();
                        busy[k] = 1'b0;
                    end
                end
                checkOutput("alu_inputs_held", k, {alu_control[k], alu_a[k], alu_b[k]}, last_pay[k]);
            end
            if (sys_rst) begin
                if (started) checkOutput("ready_in_reset", k, req_ready[k], '0);
                sb[k].delete();
                busy[k]     = 1'b0;
                holding[k]  = 1'b0;
                ptr[k]      = 0;
                last_pay[k] = '0;
            end else if (started) begin
                g = rr_pick(req_valid[k], ptr[k]);
                exp_rdy = (busy[k] || g < 0) ? '0 : (N'(1) << g);
                checkOutput("req_ready", k, req_ready[k], exp_rdy);
                if ((req_valid[k] & req_ready[k]) != '0 && !busy[k] && g >= 0) begin
                    e.id      = g;
                    e.res     = alu_fn(req_op[k][4*g +: 4], req_a[k][32*g +: 32], req_b[k][32*g +: 32]);
                    e.zero    = (e.res == 32'd0);
                    e.hs_edge = cyc + 1;
                    sb[k].push_back(e);
                    last_pay[k] = {req_op[k][4*g +: 4], req_a[k][32*g +: 32], req_b[k][32*g +: 32]};
                    busy[k] = 1'b1;
                end
                if (holding[k] && rsp_valid[k] && rsp_ready[k]) begin
                    holding[k] = 1'b0;
                    busy[k]    = 1'b0;
                    ptr[k]     = (cur_exp[k].id + 1) % N;
                end
            end
            if (end_check && !end_done) begin
                checkOutput("sb_drained", k, sb[k].size(), 0);
                checkOutput("rsp_idle_at_end", k, rsp_valid[k], 1'b0);
                if (k == 0) checkOutput("timeout", k, timeout_hit, 1'b0);
            end
        end
        if (end_check) end_done = 1'b1;
        rst_prev = sys_rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic doReset(input int n);
        sys_rst = 1'b1;
        tick(n);
        sys_rst = 1'b0;
    endtask

    task automatic setReq(input int k, input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[k][4*i +: 4]  = op;
        req_a[k][32*i +: 32] = a;
        req_b[k][32*i +: 32] = b;
    endtask

    // Raise one request and hold it until accepted, with a cycle bound.
    task automatic sendOne(input int k, input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit done;
        done = 1'b0;
        setReq(k, i, op, a, b);
        req_valid[k][i] = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge sys_clk);
            if (req_ready[k][i] && !sys_rst) done = 1'b1;
            @(posedge sys_clk);
            #1;
        end
        req_valid[k][i] = 1'b0;
        if (!done) begin
            timeout_hit = 1'b1;
            $display("[TB] wait for grant expired on dut%0d requester %0d", k, i);
        end
    endtask

    // One cycle of random requester and response-side behaviour.
    task automatic applyStimulus();
        logic [N-1:0] acc [2];
        logic [31:0]  a;
        @(negedge sys_clk);
        for (int k = 0; k < 2; k++) acc[k] = req_valid[k] & req_ready[k];
        @(posedge sys_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[k][i]) begin
                    req_valid[k][i] = 1'b0;
                end else if (req_valid[k][i]) begin
                    if ($urandom_range(99) < 5) req_valid[k][i] = 1'b0;
                end else if ($urandom_range(99) < 30) begin
                    a = ($urandom_range(3) == 0) ? 32'($urandom_range(15)) : $urandom;
                    setReq(k, i, 4'($urandom_range(15)), a, ($urandom_range(3) == 0) ? a : $urandom);
                    req_valid[k][i] = 1'b1;
                end
            end
            rsp_ready[k] = ($urandom_range(99) < 70);
        end
    endtask

    initial begin
        logic [3:0] ops [4];
        ops = '{4'd1, 4'd3, 4'd9, 4'd10};
        sys_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0;
            req_op[k]    = '0;
            req_a[k]     = '0;
            req_b[k]     = '0;
            rsp_ready[k] = 1'b1;
        end
        doReset(3);

        $display("[TB] single request, AND 2&2");
        sendOne(0, 0, 4'd0, 32'd2, 32'd2);
        tick(4);

        $display("[TB] zero flag, SUB 7-7");
        sendOne(0, 1, 4'd6, 32'd7, 32'd7);
        tick(4);

        $display("[TB] continuous round-robin over four requesters");
        doReset(1);
        for (int i = 0; i < N; i++) setReq(0, i, ops[i], $urandom, $urandom);
        req_valid[0] = '1;
        tick(15);
        req_valid[0] = '0;
        tick(4);

        $display("[TB] response back-pressure");
        rsp_ready[0] = 1'b0;
        sendOne(0, 2, 4'd2, $urandom, $urandom);
        setReq(0, 3, 4'd3, $urandom, $urandom);
        req_valid[0][3] = 1'b1;
        tick(6);
        rsp_ready[0] = 1'b1;
        tick(4);
        req_valid[0][3] = 1'b0;
        tick(4);

        $display("[TB] SETTLE=3, SRL 8>>6 on requester 2");
        sendOne(1, 2, 4'd5, 32'd8, 32'd6);
        tick(8);

        $display("[TB] reset during execution");
        sendOne(0, 1, 4'd2, $urandom, $urandom);
        sys_rst = 1'b1;
        setReq(0, 0, 4'd1, $urandom, $urandom);
        setReq(0, 3, 4'd6, $urandom, $urandom);
        req_valid[0] = 4'b1001;
        tick(1);
        sys_rst = 1'b0;
        tick(10);
        req_valid[0] = '0;
        tick(4);

        $display("[TB] random traffic");
        for (int c = 0; c < 2500; c++) applyStimulus();

        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0;
            rsp_ready[k] = 1'b1;
        end
        tick(20);
        end_check = 1'b1;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
